// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the decode/execute hazard controller.
package hazard_ctrl_pkg;

    localparam int unsigned DIV_CYCLES_DEF = 32;
    localparam int unsigned CNT_W_DEF      = 6;

    // Operand source select driven to the EX-stage operand muxes.
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_t;

    // One in-flight register write; the packed layout fixes the field offsets.
    typedef struct packed {
        logic       valid;
        logic       wr_en;
        logic [4:0] wr_reg;
        logic       is_load;
    } sb_entry_t;

    // True when the entry will write register r; $0 never matches.
    function automatic logic sb_match(sb_entry_t e, logic [4:0] r);
        return e.valid && e.wr_en && (e.wr_reg == r) && (r != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-stage hazard request/response bundle.
interface hazard_ctrl_if;

    logic       dec_valid;
    logic [4:0] dec_rs;
    logic [4:0] dec_rt;
    logic       dec_use_rs;
    logic       dec_use_rt;
    logic       dec_wr_en;
    logic [4:0] dec_wr_reg;
    logic       dec_is_load;
    logic       dec_is_div;
    logic       dec_rd_hilo;
    logic       ex_redirect;
    logic       issue;
    logic       stall;
    logic       flush_if;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       div_start;
    logic       div_busy;

    // Pipeline side: presents the decode instruction, consumes controls.
    modport master (
        output dec_valid, dec_rs, dec_rt, dec_use_rs, dec_use_rt,
               dec_wr_en, dec_wr_reg, dec_is_load, dec_is_div, dec_rd_hilo,
               ex_redirect,
        input  issue, stall, flush_if, fwd_a, fwd_b, div_start, div_busy
    );

    // Hazard controller side.
    modport slave (
        input  dec_valid, dec_rs, dec_rt, dec_use_rs, dec_use_rt,
               dec_wr_en, dec_wr_reg, dec_is_load, dec_is_div, dec_rd_hilo,
               ex_redirect,
        output issue, stall, flush_if, fwd_a, fwd_b, div_start, div_busy
    );

endinterface

// File: rtl/hazard_ctrl_div_seq.sv
// Iterative divider sequencer: start pulse and busy countdown.
module div_seq
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic launch,
    output logic div_start,
    output logic div_busy
);

    logic [CNT_W-1:0] cnt;

    // Launch loads the countdown; busy drops on the edge the count hits zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            div_busy  <= 1'b0;
            div_start <= 1'b0;
        end else begin
            div_start <= launch;
            if (launch) begin
                cnt      <= CNT_W'(DIV_CYCLES);
                div_busy <= 1'b1;
            end else if (div_busy) begin
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1))
                    div_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode/execute hazard controller: write scoreboard, forwarding selects,
// load-use and divide interlocks, fetch flush on redirect.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hif
);

    sb_entry_t sb_ex, sb_mem, sb_wb, sb_dec;
    fwd_sel_t  fwd_a, fwd_b;
    logic      load_use, div_lock, stall, issue;
    logic      div_start, div_busy;

    // Youngest writer wins; a load still in EX has no data yet, so it is
    // skipped here and handled by the load-use stall instead.
    function automatic fwd_sel_t fwd_pick(logic [4:0] r, sb_entry_t ex,
                                          sb_entry_t mem, sb_entry_t wb);
        if (sb_match(ex, r) && !ex.is_load) return FWD_EX;
        else if (sb_match(mem, r))          return FWD_MEM;
        else if (sb_match(wb, r))           return FWD_WB;
        else                                return FWD_RF;
    endfunction

    // Scoreboard image of the decode instruction.
    always_comb begin
        sb_dec         = '0;
        sb_dec.valid   = 1'b1;
        sb_dec.wr_en   = hif.dec_wr_en;
        sb_dec.wr_reg  = hif.dec_wr_reg;
        sb_dec.is_load = hif.dec_is_load;
    end

    // Interlocks, issue decision and operand forwarding selects.
    always_comb begin
        load_use = (hif.dec_use_rs && sb_match(sb_ex, hif.dec_rs) && sb_ex.is_load)
                || (hif.dec_use_rt && sb_match(sb_ex, hif.dec_rt) && sb_ex.is_load);
        div_lock = div_busy && (hif.dec_is_div || hif.dec_rd_hilo);
        stall    = hif.dec_valid && (load_use || div_lock);
        issue    = hif.dec_valid && !stall;
        fwd_a    = fwd_pick(hif.dec_rs, sb_ex, sb_mem, sb_wb);
        fwd_b    = fwd_pick(hif.dec_rt, sb_ex, sb_mem, sb_wb);
    end

    // Advance the in-flight writes; a non-issuing cycle inserts a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_ex  <= '0;
            sb_mem <= '0;
            sb_wb  <= '0;
        end else begin
            sb_ex  <= issue ? sb_dec : '0;
            sb_mem <= sb_ex;
            sb_wb  <= sb_mem;
        end
    end

    div_seq #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_div_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .launch    (issue && hif.dec_is_div),
        .div_start (div_start),
        .div_busy  (div_busy)
    );

    assign hif.issue     = issue;
    assign hif.stall     = stall;
    assign hif.flush_if  = hif.ex_redirect;
    assign hif.fwd_a     = fwd_a;
    assign hif.fwd_b     = fwd_b;
    assign hif.div_start = div_start;
    assign hif.div_busy  = div_busy;

endmodule
